dfr_run_sequencer: RTL and testbench

Sequences one reservoir run of the hybrid DFR datapath. A run is started from the AXI control register and steps through three sample phases: init (washout), train, and test. Each sample is issued to the reservoir datapath with a valid/ready handshake, and the next sample is not issued until the datapath reports completion. The block sits between the AXI config register outputs (`ctrl`, sample counts) and the reservoir/sample-memory datapath, and it drives the `busy` status back to the register block.

---
 rtl/dfr_run_sequencer.sv | 138 +++++++++++++
 tb/tb_dfr_run_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dfr_run_sequencer.sv
// dfr_run_sequencer: steps one reservoir run through init/train/test sample phases.
// Optional WAIT watchdog with sticky err is built when DFR_SEQ_TIMEOUT_EN is defined.
module dfr_run_sequencer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ctrl,
    input  logic [31:0]           num_init_samples,
    input  logic [31:0]           num_train_samples,
    input  logic [31:0]           num_test_samples,
    output logic                  smp_valid,
    input  logic                  smp_ready,
    output logic [ADDR_WIDTH-1:0] smp_addr,
    output logic [1:0]            phase,
    input  logic                  res_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           sample_count
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERROR} state_t;

    state_t                state_q;
    logic                  start_q;
    logic [31:0]           len0_q, len1_q, len2_q, cnt_q;
    logic [1:0]            phase_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  start, abort, last;
    logic [31:0]           cur_len;
    logic [1:0]            first_phase, next_phase;
    logic                  unused_ctrl;

    // Lowest phase index >= lo whose count is non-zero, or 3 when none remains.
    function automatic logic [1:0] first_nz(input logic [1:0] lo, input logic [31:0] l0, l1, l2);
        return (lo == 2'd0 && l0 != 0) ? 2'd0 :
               (lo <= 2'd1 && l1 != 0) ? 2'd1 :
               (lo <= 2'd2 && l2 != 0) ? 2'd2 : 2'd3;
    endfunction

    assign start       = ctrl[0] & ~start_q;
    assign abort       = ctrl[1];
    assign unused_ctrl = ^ctrl[31:2];
    assign cur_len     = (phase_q == 2'd0) ? len0_q : (phase_q == 2'd1) ? len1_q : len2_q;
    assign last        = (cnt_q + 32'd1) == cur_len;
    assign first_phase = first_nz(2'd0, num_init_samples, num_train_samples, num_test_samples);
    assign next_phase  = first_nz(phase_q + 2'd1, len0_q, len1_q, len2_q);

`ifdef DFR_SEQ_TIMEOUT_EN
    logic [31:0] wdog_q;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= ctrl[0]; // a start level held through reset is not an edge
            len0_q  <= '0;
            len1_q  <= '0;
            len2_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 2'd3;
            addr_q  <= '0;
`ifdef DFR_SEQ_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            start_q <= ctrl[0];
            case (state_q)
                IDLE: if (start) begin
                    len0_q  <= num_init_samples;
                    len1_q  <= num_train_samples;
                    len2_q  <= num_test_samples;
                    addr_q  <= '0;
                    cnt_q   <= '0;
                    phase_q <= first_phase;
                    state_q <= (first_phase == 2'd3) ? DONE : ISSUE;
`ifdef DFR_SEQ_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end
                ISSUE: if (abort) begin
                    state_q <= IDLE;
                    phase_q <= 2'd3;
                end else if (smp_ready) begin
                    state_q <= WAIT;
`ifdef DFR_SEQ_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                end
                WAIT: if (abort) begin
                    state_q <= IDLE;
                    phase_q <= 2'd3;
                end else if (res_done) begin
                    addr_q <= addr_q + 1'b1;
                    if (last && next_phase != 2'd3) begin
                        cnt_q   <= '0;
                        phase_q <= next_phase;
                        state_q <= ISSUE;
                    end else begin
                        cnt_q   <= cnt_q + 32'd1;
                        phase_q <= last ? 2'd3 : phase_q;
                        state_q <= last ? DONE : ISSUE;
                    end
                end
`ifdef DFR_SEQ_TIMEOUT_EN
                else if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_q <= ERROR;
                    err_q   <= 1'b1;
                end else begin
                    wdog_q <= wdog_q + 32'd1;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    phase_q <= 2'd3;
                end
                ERROR: if (abort) begin
                    state_q <= IDLE;
                    phase_q <= 2'd3;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign smp_valid    = state_q == ISSUE;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign smp_addr     = addr_q;
    assign phase        = phase_q;
    assign sample_count = cnt_q;
endmodule

// File: tb/tb_dfr_run_sequencer.sv
// tb_dfr_run_sequencer: directed run sequences with a scoreboard of expected (addr, phase) requests.
module tb_dfr_run_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctrl = '0;
    logic [31:0] n0 = '0, n1 = '0, n2 = '0;
    logic        smp_valid, smp_ready = 1'b0, res_done = 1'b0;
    logic [15:0] smp_addr;
    logic [1:0]  phase;
    logic        busy, done, err;
    logic [31:0] sample_count;

    typedef struct {
        logic [15:0] a;
        logic [1:0]  p;
    } exp_t;
    exp_t q[$];
    int   tests = 0, errors = 0;

    dfr_run_sequencer #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl),
        .num_init_samples(n0), .num_train_samples(n1), .num_test_samples(n2),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_addr(smp_addr), .phase(phase),
        .res_done(res_done), .busy(busy), .done(done), .err(err), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one run; the datapath answers res_done 3 cycles after each accept.
    // abort_idx >= 0 aborts (together with a colliding res_done) during that sample's WAIT.
    task automatic run(input logic [31:0] l0, l1, l2, input int abort_idx);
        logic [15:0] a = '0;
        logic [31:0] lens [3];
        int          n = 0, dones = 0, cyc = 0;
        bit          aborted = 0;
        exp_t        e;
        lens[0] = l0; lens[1] = l1; lens[2] = l2;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < int'(lens[p]); i++) begin
                q.push_back('{a, 2'(p)});
                a++;
            end
        n0 = l0; n1 = l1; n2 = l2;
        smp_ready = 1'b1;
        ctrl = 32'd1;
        tick();
        ctrl = '0;
        n0 = 32'd7; n1 = 32'd7; n2 = 32'd7;
        check("start_busy", busy, 1);
        check("start_err", err, 0);
        check("start_valid", smp_valid, (q.size() != 0));
        check("start_done", done, (q.size() == 0));
        while (busy && cyc < 400) begin
            cyc++;
            if (done) dones++;
            if (smp_valid) begin
                if (q.size() == 0) check("extra_req", smp_addr, 16'hffff);
                else begin
                    e = q.pop_front();
                    check("req_addr", smp_addr, e.a);
                    check("req_phase", phase, e.p);
                end
                tick();
                if (n == abort_idx) begin
                    ctrl = 32'd2;
                    res_done = 1'b1;
                    tick();
                    ctrl = '0;
                    res_done = 1'b0;
                    aborted = 1;
                    break;
                end
                n++;
                tick();
                tick();
                res_done = 1'b1;
                tick();
                res_done = 1'b0;
            end else tick();
        end
        check("run_bounded", (cyc < 400), 1);
        check("end_busy", busy, 0);
        if (aborted) begin
            check("abort_done", done, 0);
            check("abort_phase", phase, 3);
            check("abort_count", sample_count, 0);
            q.delete();
        end else begin
            check("done_pulses", dones, 1);
            check("leftover", q.size(), 0);
        end
        smp_ready = 1'b0;
        tick();
    endtask

    initial begin
        ctrl = 32'd1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", smp_valid, 0);
        check("rst_addr", smp_addr, 0);
        check("rst_phase", phase, 3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", sample_count, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_start_ignored", busy, 0);
        end
        ctrl = '0;
        tick();

        run(2, 3, 1, -1);
        run(0, 0, 0, -1);
        run(0, 2, 0, -1);

        // Backpressure with a stray res_done during ISSUE.
        n0 = 2; n1 = 0; n2 = 0;
        ctrl = 32'd1;
        tick();
        ctrl = '0;
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", smp_valid, 1);
            check("bp_addr", smp_addr, 0);
            check("bp_count", sample_count, 0);
            tick();
        end
        smp_ready = 1'b1;
        tick();
        smp_ready = 1'b0;
        check("bp_accept_drop", smp_valid, 0);
        tick();
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        check("bp_turn_valid", smp_valid, 1);
        check("bp_turn_addr", smp_addr, 1);
        check("bp_turn_count", sample_count, 1);
        smp_ready = 1'b1;
        tick();
        smp_ready = 1'b0;
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        check("bp_done", done, 1);
        tick();
        check("bp_idle", busy, 0);

        run(4, 4, 4, 4);
        run(1, 0, 1, -1);

`ifdef DFR_SEQ_TIMEOUT_EN
        n0 = 1; n1 = 0; n2 = 0;
        smp_ready = 1'b1;
        ctrl = 32'd1;
        tick();
        ctrl = '0;
        tick();
        smp_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("to_err_early", err, 0);
        tick();
        check("to_err", err, 1);
        check("to_busy", busy, 1);
        ctrl = 32'd2;
        tick();
        ctrl = '0;
        check("to_abort_idle", busy, 0);
        check("to_err_sticky", err, 1);
        tick();
        run(1, 0, 0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
